// File: rtl/result_matrix_collector.sv
// Captures the multiplier's C-element write stream into a ROWS x COLS store,
// then streams the completed matrix out row-major over a valid/ready handshake.
module result_matrix_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_WriteMat_C,
  input  logic [3:0]            rowAddr_C,
  input  logic [3:0]            colAddr_C,
  input  logic [DATA_WIDTH-1:0] writeData_C,
  input  logic                  resultIsInvalid,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [3:0]            outRow,
  output logic [3:0]            outCol,
  output logic                  outLast,
  output logic                  matInvalid,
  output logic                  dupWrite,
  output logic                  errOverrun,
  output logic                  matDone
);

  localparam int TOTAL = ROWS * COLS;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [4:0] ROWS_L   = 5'(ROWS);
  localparam logic [4:0] COLS_L   = 5'(COLS);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(COLS - 1);
  localparam logic [8:0] FILL_M1  = 9'(TOTAL - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [TOTAL];
  logic [TOTAL-1:0]      written;
  logic [8:0]            count;
  logic [3:0]            ptr_row, ptr_col;

  logic                  in_range;
  logic [7:0]            wr_flat, rd_flat;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  last_elem;
  logic                  accept, is_new, drop, handshake;

  always_comb begin
    in_range  = ({1'b0, rowAddr_C} < ROWS_L) && ({1'b0, colAddr_C} < COLS_L);
    wr_flat   = 8'(rowAddr_C) * 8'(COLS) + 8'(colAddr_C);
    rd_flat   = 8'(ptr_row) * 8'(COLS) + 8'(ptr_col);
    wr_idx    = wr_flat[IDX_W-1:0];
    rd_idx    = rd_flat[IDX_W-1:0];
    last_elem = (ptr_row == ROW_LAST) && (ptr_col == COL_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_next;
  end

  // Out-of-range addresses never reach the bitmap lookup because accept gates is_new.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    is_new     = 1'b0;
    drop       = 1'b0;
    handshake  = 1'b0;
    case (state)
      COLLECT: begin
        if (en_WriteMat_C) begin
          if (in_range) accept = 1'b1;
          else          drop   = 1'b1;
        end
        is_new = accept && !written[wr_idx];
        if (is_new && (count == FILL_M1)) state_next = DRAIN;
      end
      DRAIN: begin
        drop      = en_WriteMat_C;
        handshake = outReady;
        if (handshake && last_elem) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    outValid = (state == DRAIN);
    outLast  = outValid && last_elem;
    outRow   = ptr_row;
    outCol   = ptr_col;
    outData  = outValid ? mem[rd_idx] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TOTAL; i++) mem[i] <= '0;
      written    <= '0;
      count      <= '0;
      ptr_row    <= '0;
      ptr_col    <= '0;
      matInvalid <= 1'b0;
      dupWrite   <= 1'b0;
      errOverrun <= 1'b0;
      matDone    <= 1'b0;
    end else begin
      matDone <= 1'b0;
      if (accept) begin
        mem[wr_idx] <= writeData_C;
        if (is_new) begin
          written[wr_idx] <= 1'b1;
          count           <= count + 9'd1;
        end else begin
          dupWrite <= 1'b1;
        end
        if (resultIsInvalid) matInvalid <= 1'b1;
      end
      if (drop) errOverrun <= 1'b1;
      // The final handshake retires the matrix; the store itself is left as-is.
      if (handshake) begin
        if (last_elem) begin
          ptr_row    <= '0;
          ptr_col    <= '0;
          written    <= '0;
          count      <= '0;
          matInvalid <= 1'b0;
          dupWrite   <= 1'b0;
          matDone    <= 1'b1;
        end else if (ptr_col == COL_LAST) begin
          ptr_col <= '0;
          ptr_row <= ptr_row + 4'd1;
        end else begin
          ptr_col <= ptr_col + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_matrix_collector.sv
// Randomized self-checking bench for result_matrix_collector against a
// behavioural matrix/flag model kept in plain arrays.
module tb_result_matrix_collector;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R * C;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en_WriteMat_C = 1'b0;
  logic [3:0]    rowAddr_C = '0;
  logic [3:0]    colAddr_C = '0;
  logic [DW-1:0] writeData_C = '0;
  logic          resultIsInvalid = 1'b0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [DW-1:0] outData;
  logic [3:0]    outRow;
  logic [3:0]    outCol;
  logic          outLast;
  logic          matInvalid;
  logic          dupWrite;
  logic          errOverrun;
  logic          matDone;

  int checks = 0;
  int errors = 0;

  // Reference model: element values, which elements are present, and flags.
  int exp_mem [N];
  bit exp_written [N];
  int exp_count;
  bit exp_inv, exp_dup, exp_err, exp_drain;
  int stim_data [N];

  result_matrix_collector #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .reset_n(reset_n), .en_WriteMat_C(en_WriteMat_C),
    .rowAddr_C(rowAddr_C), .colAddr_C(colAddr_C), .writeData_C(writeData_C),
    .resultIsInvalid(resultIsInvalid), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outRow(outRow), .outCol(outCol), .outLast(outLast),
    .matInvalid(matInvalid), .dupWrite(dupWrite), .errOverrun(errOverrun),
    .matDone(matDone)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_mem[i] = 0;
      exp_written[i] = 0;
    end
    exp_count = 0;
    exp_inv = 0;
    exp_dup = 0;
    exp_err = 0;
    exp_drain = 0;
  endtask

  // Drives one write across the next rising edge and updates the model.
  task automatic do_write(input int r, input int c, input int d, input bit inv);
    int idx;
    en_WriteMat_C = 1'b1;
    rowAddr_C = 4'(r);
    colAddr_C = 4'(c);
    writeData_C = DW'(d);
    resultIsInvalid = inv;
    @(negedge clk);
    en_WriteMat_C = 1'b0;
    resultIsInvalid = 1'b0;
    if (exp_drain || r >= R || c >= C) begin
      exp_err = 1;
    end else begin
      idx = r * C + c;
      exp_mem[idx] = d;
      if (exp_written[idx]) exp_dup = 1;
      else begin
        exp_written[idx] = 1;
        exp_count++;
      end
      if (inv) exp_inv = 1;
      if (exp_count == N) exp_drain = 1;
    end
  endtask

  // Writes every element of stim_data in a random order; keep_not_last names an
  // element that must not be the final write (-1 for none).
  task automatic fill_matrix(input int inv_idx, input int keep_not_last);
    int order [N];
    int j, t;
    for (int i = 0; i < N; i++) order[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    if (keep_not_last >= 0 && order[N-1] == keep_not_last) begin
      order[N-1] = order[0];
      order[0] = keep_not_last;
    end
    for (int i = 0; i < N; i++) begin
      do_write(order[i] / C, order[i] % C, stim_data[order[i]], order[i] == inv_idx);
      checks++;
      if (outValid !== exp_drain)
        $display("FAIL fill_valid write %0d: outValid=%b expected=%b", i, outValid, exp_drain);
      if (outValid !== exp_drain) errors++;
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic drain_and_check(input int mode, input bit inject, output int cycles);
    int idx = 0;
    int cyc = 0;
    bit held = 0;
    logic [DW-1:0] held_d;
    logic [3:0] held_r, held_c;
    while (idx < N && cyc < 300) begin
      case (mode)
        0: outReady = 1'b1;
        1: outReady = (cyc % 3 == 0);
        default: outReady = 1'($urandom_range(0, 1));
      endcase
      if (inject && cyc == 2) begin
        en_WriteMat_C = 1'b1;
        rowAddr_C = 4'd0;
        colAddr_C = 4'd0;
        writeData_C = ~DW'(exp_mem[0]);
        exp_err = 1;
      end
      checks += 7;
      if (outValid !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid elem %0d: outValid=%b expected=1", idx, outValid);
      end
      if (outData !== DW'(exp_mem[idx])) begin
        errors++;
        $display("FAIL drain_data elem %0d: outData=%0d expected=%0d", idx, outData, exp_mem[idx]);
      end
      if (outRow !== 4'(idx / C) || outCol !== 4'(idx % C)) begin
        errors++;
        $display("FAIL drain_addr elem %0d: row/col=%0d/%0d expected=%0d/%0d", idx, outRow, outCol, idx / C, idx % C);
      end
      if (outLast !== (idx == N - 1)) begin
        errors++;
        $display("FAIL drain_last elem %0d: outLast=%b expected=%b", idx, outLast, idx == N - 1);
      end
      if (matInvalid !== exp_inv) begin
        errors++;
        $display("FAIL drain_matInvalid elem %0d: got=%b expected=%b", idx, matInvalid, exp_inv);
      end
      if (dupWrite !== exp_dup) begin
        errors++;
        $display("FAIL drain_dupWrite elem %0d: got=%b expected=%b", idx, dupWrite, exp_dup);
      end
      if (held && (outData !== held_d || outRow !== held_r || outCol !== held_c)) begin
        errors++;
        $display("FAIL drain_stable elem %0d: data/row/col=%0d/%0d/%0d held=%0d/%0d/%0d", idx, outData, outRow, outCol, held_d, held_r, held_c);
      end
      held = !outReady;
      held_d = outData;
      held_r = outRow;
      held_c = outCol;
      @(negedge clk);
      en_WriteMat_C = 1'b0;
      cyc++;
      if (outReady) idx++;
    end
    outReady = 1'b0;
    cycles = cyc;
    if (idx < N) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: drained=%0d expected=%0d", idx, N);
    end
    checks += 5;
    if (matDone !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: matDone=%b expected=1", matDone);
    end
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL done_valid: outValid=%b expected=0", outValid);
    end
    if (matInvalid !== 1'b0) begin
      errors++;
      $display("FAIL done_matInvalid: got=%b expected=0", matInvalid);
    end
    if (dupWrite !== 1'b0) begin
      errors++;
      $display("FAIL done_dupWrite: got=%b expected=0", dupWrite);
    end
    if (errOverrun !== exp_err) begin
      errors++;
      $display("FAIL done_errOverrun: got=%b expected=%b", errOverrun, exp_err);
    end
    for (int i = 0; i < N; i++) exp_written[i] = 0;
    exp_count = 0;
    exp_inv = 0;
    exp_dup = 0;
    exp_drain = 0;
  endtask

  task automatic test_reset();
    int cyc;
    model_reset();
    #1;
    checks++;
    if ({outValid, outLast, matInvalid, dupWrite, errOverrun, matDone, outData} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got=%b expected all 0", {outValid, outLast, matInvalid, dupWrite, errOverrun, matDone, outData});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_write(5, 0, 1, 0);
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    do_write(0, 2, stim_data[2], 1);
    do_write(0, 2, stim_data[2], 0);
    fill_matrix(-1, -1);
    outReady = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({outValid, outLast, matInvalid, dupWrite, errOverrun, matDone} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_drain: valid/last/inv/dup/err/done=%b expected 000000", {outValid, outLast, matInvalid, dupWrite, errOverrun, matDone});
    end
    outReady = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    fill_matrix(-1, -1);
    drain_and_check(2, 0, cyc);
  endtask

  task automatic test_full_matrix();
    int cyc;
    for (int i = 0; i < N; i++) stim_data[i] = i;
    fill_matrix(-1, -1);
    drain_and_check(0, 0, cyc);
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL full_cycles: drain took %0d cycles expected %0d", cyc, N);
    end
    @(negedge clk);
    checks++;
    if (matDone !== 1'b0) begin
      errors++;
      $display("FAIL done_width: matDone=%b expected=0", matDone);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    fill_matrix(-1, -1);
    drain_and_check(1, 0, cyc);
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    fill_matrix(-1, -1);
    drain_and_check(2, 0, cyc);
  endtask

  task automatic test_flags();
    int cyc;
    resultIsInvalid = 1'b1;
    @(negedge clk);
    resultIsInvalid = 1'b0;
    checks++;
    if (matInvalid !== 1'b0) begin
      errors++;
      $display("FAIL inv_without_strobe: matInvalid=%b expected=0", matInvalid);
    end
    do_write(1, 1, 5, 0);
    checks++;
    if (dupWrite !== exp_dup) begin
      errors++;
      $display("FAIL dup_first_write: dupWrite=%b expected=%b", dupWrite, exp_dup);
    end
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    stim_data[1 * C + 1] = 9;
    fill_matrix(2 * C + 3, 1 * C + 1);
    checks += 2;
    if (matInvalid !== exp_inv) begin
      errors++;
      $display("FAIL flags_matInvalid: got=%b expected=%b", matInvalid, exp_inv);
    end
    if (dupWrite !== exp_dup) begin
      errors++;
      $display("FAIL flags_dupWrite: got=%b expected=%b", dupWrite, exp_dup);
    end
    drain_and_check(2, 0, cyc);
  endtask

  task automatic test_errors();
    int cyc;
    checks++;
    if (errOverrun !== exp_err) begin
      errors++;
      $display("FAIL err_before: errOverrun=%b expected=%b", errOverrun, exp_err);
    end
    do_write(4, 0, 77, 0);
    checks++;
    if (errOverrun !== exp_err) begin
      errors++;
      $display("FAIL err_range: errOverrun=%b expected=%b", errOverrun, exp_err);
    end
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    fill_matrix(-1, -1);
    drain_and_check(0, 1, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    fill_matrix(-1, -1);
    drain_and_check(2, 0, cyc);
    for (int i = 0; i < N; i++) stim_data[i] = int'($urandom_range(0, 255));
    fill_matrix(-1, -1);
    drain_and_check(0, 0, cyc);
  endtask

  initial begin
    test_reset();
    test_full_matrix();
    test_backpressure();
    test_flags();
    test_errors();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
